// File: rtl/stream_upsizer.sv
// rtl/stream_upsizer.sv - AXI-Stream width up-converter packing RATIO narrow beats into one word
module stream_upsizer #(
    parameter int IN_WIDTH = 4,
    parameter int RATIO    = 4,
    parameter int WIDTH    = IN_WIDTH * RATIO
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                s_axis_tvalid,
    input  logic [IN_WIDTH-1:0] s_axis_tdata,
    input  logic                s_axis_tlast,
    output logic                s_axis_tready,
    output logic                m_axis_tvalid,
    output logic [WIDTH-1:0]    m_axis_tdata,
    output logic                m_axis_tlast,
    input  logic                m_axis_tready
);
    localparam int CW = $clog2(RATIO);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] stage;
    logic [WIDTH-1:0] word;
    logic             closing;
    logic             out_free;
    logic             accept;

    assign closing  = (cnt == CW'(RATIO - 1)) || s_axis_tlast;
    assign out_free = !m_axis_tvalid || m_axis_tready;

    // Only a closing beat needs the output register; partial beats go to staging.
    assign s_axis_tready = !areset && (!closing || out_free);
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_comb begin
        word = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (CW'(i) < cnt) begin
                word[i*IN_WIDTH +: IN_WIDTH] = stage[i*IN_WIDTH +: IN_WIDTH];
            end else if (CW'(i) == cnt) begin
                word[i*IN_WIDTH +: IN_WIDTH] = s_axis_tdata;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt           <= '0;
            stage         <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (accept) begin
                if (closing) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= word;
                    m_axis_tlast  <= s_axis_tlast;
                    cnt           <= '0;
                    stage         <= '0;
                end else begin
                    stage[cnt*IN_WIDTH +: IN_WIDTH] <= s_axis_tdata;
                    cnt                             <= cnt + 1'b1;
                end
            end
        end
    end
endmodule
